// File: rtl/seqdet_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
// Reset configuration reproduces the original fixed "101" overlapping detector.
package seqdet_pkg;

    localparam logic [2:0] DEF_PAT  = 3'b101;
    localparam int         DEF_LEN  = 3;
    localparam logic       DEF_OVL  = 1'b1;
    localparam int         MASK_MAX = 256;

    // Callers size-cast the result down to their own pattern width.
    function automatic logic [MASK_MAX-1:0] lenMask(input int unsigned len);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_MAX; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/seqdet_if.sv
// Stream, configuration and result signals of the sequence detector.
// The master side drives samples and config; the slave side is the detector.
interface seqdet_if #(
    parameter int N     = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(N + 1)
) ();

    logic             x;
    logic             valid;
    logic             pat_load;
    logic [N-1:0]     pat_in;
    logic [LEN_W-1:0] len_in;
    logic             ovl_in;
    logic             cnt_clr;
    logic             y;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output x, valid, pat_load, pat_in, len_in, ovl_in, cnt_clr,
        input  y, match_cnt
    );

    modport slave (
        input  x, valid, pat_load, pat_in, len_in, ovl_in, cnt_clr,
        output y, match_cnt
    );

endinterface

// File: rtl/seqdet_match.sv
// Combinational masked compare of the sample window against the pattern.
// Only the low len bits count, and only once enough fresh samples exist.
module seqdet_match
    import seqdet_pkg::*;
#(
    parameter int N     = 8,
    parameter int LEN_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     i_window,
    input  logic [N-1:0]     i_pat,
    input  logic [LEN_W-1:0] i_len,
    input  logic [LEN_W-1:0] i_fill,
    output logic             o_match
);

    logic [N-1:0] w_mask;
    logic         w_enough;

    assign w_mask   = N'(lenMask(32'(i_len)));
    // Extra bit so fill+1 cannot wrap when fill already sits at N.
    assign w_enough = ({1'b0, i_fill} + (LEN_W + 1)'(1)) >= {1'b0, i_len};
    assign o_match  = (i_len != '0) && w_enough &&
                      ((i_window & w_mask) == (i_pat & w_mask));

endmodule

// File: rtl/seqdet_param.sv
// Parametrised serial sequence detector with runtime-loadable pattern,
// overlap/non-overlap modes, registered match pulse and saturating counter.
module seqdet_param
    import seqdet_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(N + 1)
) (
    input  logic     clk,
    input  logic     rst,
    seqdet_if.slave  bus
);

    logic [N-1:0]     r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic [N-1:0]     r_hist;
    logic [LEN_W-1:0] r_fill;
    logic             r_y;
    logic [CNT_W-1:0] r_cnt;

    logic [N-1:0]     w_window;
    logic             w_match;
    logic             w_hit;
    logic [LEN_W-1:0] w_lenClamp;
    logic [LEN_W-1:0] w_fillNext;

    assign w_window   = {r_hist[N-2:0], bus.x};
    assign w_hit      = w_match & bus.valid & ~bus.pat_load;
    assign w_lenClamp = (bus.len_in > LEN_W'(N)) ? LEN_W'(N) : bus.len_in;

    seqdet_match #(
        .N     (N),
        .LEN_W (LEN_W)
    ) u_match (
        .i_window (w_window),
        .i_pat    (r_pat),
        .i_len    (r_len),
        .i_fill   (r_fill),
        .o_match  (w_match)
    );

    // A non-overlap match restarts the fresh-sample count from zero.
    always_comb begin
        w_fillNext = r_fill;
        if (w_hit && !r_ovl) begin
            w_fillNext = '0;
        end else if (r_fill != LEN_W'(N)) begin
            w_fillNext = r_fill + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat  <= N'(DEF_PAT);
            r_len  <= LEN_W'(DEF_LEN);
            r_ovl  <= DEF_OVL;
            r_hist <= '0;
            r_fill <= '0;
            r_y    <= 1'b0;
        end else if (bus.pat_load) begin
            r_pat  <= bus.pat_in;
            r_len  <= w_lenClamp;
            r_ovl  <= bus.ovl_in;
            r_hist <= '0;
            r_fill <= '0;
            r_y    <= 1'b0;
        end else if (bus.valid) begin
            r_hist <= w_window;
            r_fill <= w_fillNext;
            r_y    <= w_hit;
        end else begin
            r_y    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_cnt <= w_hit ? CNT_W'(1) : '0;
        end else if (w_hit && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.y         = r_y;
    assign bus.match_cnt = r_cnt;

endmodule

// File: tb/tb_seqdet_param.sv
// Directed bench for seqdet_param: a queue-based reference model checked every
// cycle, plus hand-computed pulse traces and counter values per scenario.
module tb_seqdet_param;

    localparam int N     = 8;
    localparam int CNT_W = 8;
    localparam int LEN_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seqdet_if #(.N(N), .CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

    seqdet_param #(.N(N), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    bit cmpOn = 1'b0;

    logic [N-1:0] mPat;
    int           mLen;
    logic         mOvl;
    logic         mSince[$];
    logic         mY;
    int           mCnt;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mPat = 8'b101;
        mLen = 3;
        mOvl = 1'b1;
        mSince.delete();
        mY   = 1'b0;
        mCnt = 0;
    endtask

    // Match = the last len fresh samples, newest first, equal pat[0..len-1].
    task automatic modelStep();
        logic hit;
        hit = 1'b0;
        if (bus.pat_load) begin
            mPat = bus.pat_in;
            mLen = (int'(bus.len_in) > N) ? N : int'(bus.len_in);
            mOvl = bus.ovl_in;
            mSince.delete();
        end else if (bus.valid) begin
            mSince.push_back(bus.x);
            if (mSince.size() > N) void'(mSince.pop_front());
            if (mLen > 0 && mSince.size() >= mLen) begin
                hit = 1'b1;
                for (int k = 0; k < mLen; k++) begin
                    if (mSince[mSince.size() - 1 - k] !== mPat[k]) hit = 1'b0;
                end
            end
            if (hit && !mOvl) mSince.delete();
        end
        mY = hit;
        if (bus.cnt_clr) mCnt = hit ? 1 : 0;
        else if (hit && mCnt < (2 ** CNT_W) - 1) mCnt++;
    endtask

    task automatic applyStimulus(input logic xv, input logic vv, input logic ld, input logic clr);
        bus.x        = xv;
        bus.valid    = vv;
        bus.pat_load = ld;
        bus.cnt_clr  = clr;
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic loadCfg(input logic [N-1:0] p, input logic [LEN_W-1:0] l, input logic o,
                           input logic vv, input logic xv);
        bus.pat_in = p;
        bus.len_in = l;
        bus.ovl_in = o;
        applyStimulus(xv, vv, 1'b1, 1'b0);
    endtask

    // Trace bit i holds y after the (i+1)-th valid sample.
    task automatic sendSeq(input logic [31:0] bits, input int n, input int gaps,
                           output logic [31:0] dutTr, output logic [31:0] modTr, output int gapHigh);
        logic xg;
        dutTr   = '0;
        modTr   = '0;
        gapHigh = 0;
        xg      = 1'b0;
        for (int i = 0; i < n; i++) begin
            applyStimulus(bits[n - 1 - i], 1'b1, 1'b0, 1'b0);
            dutTr[i] = bus.y;
            modTr[i] = mY;
            for (int g = 0; g < gaps; g++) begin
                xg = ~xg;
                applyStimulus(xg, 1'b0, 1'b0, 1'b0);
                gapHigh += int'(bus.y);
            end
        end
    endtask

    task automatic resetPulse();
        #1 rst = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_mid_y", 32'(bus.y), 32'd0);
        checkOutput("rst_mid_cnt", 32'(bus.match_cnt), 32'd0);
        #1 rst = 1'b1;
    endtask

    task automatic checkTrace(input string name, input logic [31:0] dutTr,
                              input logic [31:0] modTr, input logic [31:0] exp);
        checkOutput({name, "_dut"}, dutTr, exp);
        checkOutput({name, "_model"}, modTr, exp);
    endtask

    always @(negedge clk) begin
        if (cmpOn && rst) begin
            checkOutput("y_cycle", 32'(bus.y), 32'(mY));
            checkOutput("cnt_cycle", 32'(bus.match_cnt), mCnt);
        end
    end

    initial begin
        logic [31:0] dTr;
        logic [31:0] mTr;
        int          gh;

        bus.x = 1'b0; bus.valid = 1'b0; bus.pat_load = 1'b0; bus.cnt_clr = 1'b0;
        bus.pat_in = '0; bus.len_in = '0; bus.ovl_in = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checkOutput("reset_y", 32'(bus.y), 32'd0);
        checkOutput("reset_cnt", 32'(bus.match_cnt), 32'd0);
        cmpOn = 1'b1;

        // Default 101 overlapping
        sendSeq(32'b10101, 5, 0, dTr, mTr, gh);
        checkTrace("def_ovl_trace", dTr, mTr, 32'h14);
        checkOutput("def_ovl_cnt", 32'(bus.match_cnt), 32'd2);

        // 101 non-overlapping
        loadCfg(8'b101, 4'd3, 1'b0, 1'b0, 1'b0);
        sendSeq(32'b10101101, 8, 0, dTr, mTr, gh);
        checkTrace("novl_trace", dTr, mTr, 32'h84);
        checkOutput("novl_cnt", 32'(bus.match_cnt), 32'd4);

        // Full-width pattern with toggling gap bits
        loadCfg(8'b11010011, 4'd8, 1'b1, 1'b0, 1'b0);
        sendSeq(32'b11010011, 8, 2, dTr, mTr, gh);
        checkTrace("gap_trace", dTr, mTr, 32'h80);
        checkOutput("gap_no_pulse", 32'(gh), 32'd0);
        checkOutput("gap_cnt", 32'(bus.match_cnt), 32'd5);

        // len = 0 disables detection even for an all-zero pattern
        loadCfg(8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
        sendSeq(32'b0, 10, 0, dTr, mTr, gh);
        checkTrace("len0_trace", dTr, mTr, 32'h0);
        checkOutput("len0_cnt", 32'(bus.match_cnt), 32'd5);

        // len_in 12 clamps to 8
        loadCfg(8'hFF, 4'd12, 1'b1, 1'b0, 1'b0);
        sendSeq(32'h1FF, 9, 0, dTr, mTr, gh);
        checkTrace("clamp_trace", dTr, mTr, 32'h180);
        checkOutput("clamp_cnt", 32'(bus.match_cnt), 32'd7);

        // Sample on the load edge is discarded
        loadCfg(8'b11, 4'd2, 1'b1, 1'b1, 1'b1);
        sendSeq(32'b11, 2, 0, dTr, mTr, gh);
        checkTrace("load_valid_trace", dTr, mTr, 32'h2);
        checkOutput("load_valid_cnt", 32'(bus.match_cnt), 32'd8);

        // Saturation and clear-with-match
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("sat_cnt", 32'(bus.match_cnt), 32'd255);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("clr_match_y", 32'(bus.y), 32'd1);
        checkOutput("clr_match_cnt", 32'(bus.match_cnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_idle_cnt", 32'(bus.match_cnt), 32'd0);

        // Reset while y is high and mid-sequence
        sendSeq(32'b11, 2, 0, dTr, mTr, gh);
        checkTrace("pre_rst_trace", dTr, mTr, 32'h3);
        resetPulse();
        sendSeq(32'b10, 2, 0, dTr, mTr, gh);
        checkTrace("post_rst_partial", dTr, mTr, 32'h0);
        resetPulse();
        sendSeq(32'b101, 3, 0, dTr, mTr, gh);
        checkTrace("post_rst_trace", dTr, mTr, 32'h4);
        checkOutput("post_rst_cnt", 32'(bus.match_cnt), 32'd1);

        cmpOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seqdet_param.md
# seqdet_param

Parametrised serial sequence detector. It watches a 1-bit input stream for a runtime-loadable pattern of up to N bits, with overlapping or non-overlapping detection. It emits a registered one-cycle match pulse and keeps a saturating match counter. It is the generalised successor of the fixed "101" Mealy detector in the FSM lab set, and its reset configuration reproduces that detector exactly.

## Interface
Parameters:
- N, default 8: maximum pattern length in bits (N ≥ 2).
- CNT_W, default 8: match counter width.
- LEN_W, default $clog2(N+1): width of the length field.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- x  in  1  serial data bit.
- valid  in  1  x is sampled only on edges where valid=1.
- pat_load  in  1  load pat_in/len_in/ovl_in into the config registers.
- pat_in  in  N  pattern. pat_in[len-1] is the first bit received; pat_in[0] is the last.
- len_in  in  LEN_W  pattern length.
- ovl_in  in  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  in  1  synchronous clear of match_cnt.
- y  out  1  registered match pulse.
- match_cnt  out  CNT_W  number of matches, saturating.

## Operation
- Registers:
  - pat (N bits), len (LEN_W), ovl.
  - hist: N-bit shift register of past samples; the newest sample is at bit 0.
  - fill: count of samples since reset, load, or the last non-overlap match; saturates at N.
  - y, match_cnt.
- Reset values: pat = 'b101 (zero-extended), len = 3, ovl = 1, hist = 0, fill = 0, y = 0, match_cnt = 0.
- Sample edge (valid=1, pat_load=0):
  - hist ← {hist[N-2:0], x}.
  - Combinational match = (len ≠ 0) AND (fill+1 ≥ len) AND ({hist[N-2:0],x} masked to the low len bits == pat masked to the low len bits).
  - y ← match.
  - fill ← 0 if match and ovl=0; otherwise min(fill+1, N).
- Non-sample edge (valid=0): hist and fill hold, y ← 0. Bits on x are ignored.
- pat_load=1:
  - pat ← pat_in, len ← min(len_in, N), ovl ← ovl_in.
  - hist ← 0, fill ← 0, y ← 0.
  - Any sample on the same edge is discarded.
  - pat_load has priority over valid.
- len = 0: the detector is disabled; y is never asserted.
- match_cnt:
  - Increments on each edge where match=1, and saturates at 2^CNT_W−1.
  - cnt_clr=1 sets it to 0, or to 1 if a match occurs on the same edge.
  - pat_load does not clear match_cnt.
- Overlap mode: the tail of a match may start the next match, so "10101" gives 2 matches for "101".
- Non-overlap mode: a new match needs len fresh samples after the previous one, so "10101" gives 1 match.

## Timing
- Latency: y rises on the same clk edge that samples the final pattern bit. It is high for exactly one cycle per match.
- Back-to-back matches: in overlap mode with a period-1 pattern (e.g. "11"), y stays high on consecutive sample edges.
- No output is combinational from x; y and match_cnt come only from flops.
- Reset asserted mid-sequence:
  - All registers take their reset values immediately (asynchronous).
  - The partial sequence is lost.
  - The first edge after rst deasserts starts from fill = 0.

## Structure
- Package seqdet_pkg holds:
  - Default constants: DEF_PAT = 'b101, DEF_LEN = 3, DEF_OVL = 1.
  - The length-to-mask function: len → N-bit mask of the low len bits.
- Sub-module seqdet_match: purely combinational masked compare. Inputs are window, pat, len and fill; output is match.
- The top level holds all registers and the counter.

## Test plan
- Reset defaults, valid=1, x = 1,0,1,0,1 → y pulses after the 3rd and 5th samples; match_cnt = 2.
- Load pat='b101, len=3, ovl=0, then x = 1,0,1,0,1,1,0,1 → y pulses after the 3rd and 8th samples only; match_cnt increments by 2.
- Load pat='b11010011, len=8, ovl=1. Stream 1,1,0,1,0,0,1,1 with valid=0 gaps in which x toggles → exactly one pulse, on the 8th valid sample. Gap bits have no effect.
- Saturation, CNT_W=8, overlap, pat="11", len=2: hold x=1 for 300 valid edges → match_cnt = 255. Then cnt_clr together with a match → match_cnt = 1.
- Reset mid-operation: after samples 1,0, pulse rst low → y = 0, match_cnt = 0, config back to 101. Next sample 1 → no pulse.
- Boundaries:
  - len_in = 0 → no pulse on any stream.
  - len_in = 12 with N = 8 → len = 8.
  - pat_load on the same edge as valid → that sample is discarded and fill = 0.
